// File: rtl/packer_pkg.sv
// Shared constants and types for the byte packer.
//   BYTE_W - width of one input byte
//   LANES  - byte lanes per output word
//   WORD_W - width of the packed output word
//   LVL_W  - width of the lane-level counter
//   state_t - packer FSM state: FILL (collecting bytes) / FULL (word pending)
package packer_pkg;
  localparam int BYTE_W = 8;
  localparam int LANES  = 16;
  localparam int WORD_W = 128;
  localparam int LVL_W  = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;
endpackage

// File: rtl/byte_packer_if.sv
// Bundle of the byte-in / word-out handshakes of the byte packer.
//   clear              - synchronous abort of any partial or pending word
//   in_valid/in_byte   - byte stream from the producer
//   in_ready           - packer accepts in_byte this cycle
//   out_valid/out_word - completed 128-bit word, byte k at [8k+7:8k]
//   out_ready          - consumer takes out_word this cycle
//   level              - lanes written in the word being filled
// Modports: master = producer/consumer side, slave = the packer.
interface byte_packer_if;
  import packer_pkg::*;

  logic                 clear;
  logic                 in_valid;
  logic [BYTE_W-1:0]    in_byte;
  logic                 in_ready;
  logic                 out_valid;
  logic [WORD_W-1:0]    out_word;
  logic                 out_ready;
  logic [LVL_W-1:0]     level;

  modport master (
    output clear, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, out_word, level
  );

  modport slave (
    input  clear, in_valid, in_byte, out_ready,
    output in_ready, out_valid, out_word, level
  );
endinterface

// File: rtl/byte_lane_demux.sv
// Lane write-enable decoder: turns the current fill level into a one-hot
// write strobe for the byte lane that receives the next accepted byte.
// Mirror image of a 16-way byte-select mux.
//   level   - lane index to be written (0..15)
//   accept  - a byte is being accepted this cycle
//   lane_we - one-hot lane write enables (all zero when not accepting)
module byte_lane_demux
  import packer_pkg::*;
(
  input  logic [LVL_W-1:0] level,
  input  logic             accept,
  output logic [LANES-1:0] lane_we
);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_we
      assign lane_we[gi] = accept && (level == LVL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/byte_packer.sv
// Byte-serial to 128-bit word packer. Bytes accepted over the input
// handshake are written into successive byte lanes; once all 16 lanes are
// filled the word is offered on the output handshake. While a word is
// pending, a new byte is only taken in the same cycle the word is handed
// off, so a full-rate stream flows with no bubble at word boundaries.
//   clk - system clock, rising edge
//   rst - synchronous active-high reset (overrides clear)
//   bus - byte_packer_if slave modport (handshakes, clear, level)
module byte_packer
  import packer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  byte_packer_if.slave  bus
);

  state_t               state_reg;
  logic [LVL_W-1:0]     level_reg;
  logic [BYTE_W-1:0]    lane_reg [LANES];
  logic [LANES-1:0]     lane_we;
  logic [WORD_W-1:0]    word_flat;
  logic                 accept;
  logic                 handoff;

  // In FULL the only way to take a byte is alongside the hand-off; clear
  // blocks both directions for its cycle.
  assign bus.in_ready  = !bus.clear && ((state_reg == FILL) || bus.out_ready);
  assign bus.out_valid = (state_reg == FULL);
  assign bus.level     = level_reg;

  assign accept  = bus.in_valid && bus.in_ready;
  assign handoff = (state_reg == FULL) && bus.out_ready && !bus.clear;

  byte_lane_demux u_demux (
    .level   (level_reg),
    .accept  (accept),
    .lane_we (lane_we)
  );

  // One register per byte lane; clear leaves lane contents untouched, and
  // since accept is already suppressed during clear no extra gating is needed.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (lane_we[gi]) begin
          lane_reg[gi] <= bus.in_byte;
        end
      end
    end
  endgenerate

  always_comb begin
    word_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      word_flat[i*BYTE_W +: BYTE_W] = lane_reg[i];
    end
  end

  assign bus.out_word = word_flat;

  // Level is 0 throughout FULL (it wrapped on the 16th byte), so a byte
  // accepted together with the hand-off lands in lane 0 and level goes to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      level_reg <= '0;
    end else if (bus.clear) begin
      state_reg <= FILL;
      level_reg <= '0;
    end else begin
      if (accept) begin
        level_reg <= level_reg + 1'b1;
      end
      case (state_reg)
        FILL: begin
          if (accept && (level_reg == LVL_W'(LANES - 1))) begin
            state_reg <= FULL;
          end
        end
        FULL: begin
          if (handoff) begin
            state_reg <= FILL;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios followed by a
// random stretch, all compared against a byte-queue reference model.
module tb_byte_packer;
  import packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  byte_packer_if bus ();

  byte_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model: bytes collected for the word in progress, plus the
  // completed word awaiting hand-off.
  byte unsigned       pend[$];
  logic               m_full;
  logic [127:0]       m_word;
  logic               m_known;
  int                 m_handoffs;

  int                 vectors;
  int                 miscompares;
  int                 cyc;
  int                 dut_handoff_cyc[$];
  logic [127:0]       dut_words[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus: drive, check outputs mid-cycle against the
  // model, take the edge, then advance the model.
  task automatic step(input logic iv, input logic [7:0] ib, input logic ordy,
                      input logic clr, input logic rs);
    logic exp_rdy;
    logic acc;
    bus.in_valid  = iv;
    bus.in_byte   = ib;
    bus.out_ready = ordy;
    bus.clear     = clr;
    rst           = rs;
    #4;
    exp_rdy = !clr && (!m_full || ordy);
    if (m_known) begin
      chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(bus.out_valid), 128'(m_full));
      chk("level", 128'(bus.level), 128'(pend.size()));
      if (m_full) chk("out_word", bus.out_word, m_word);
      if (bus.out_valid && ordy && !clr && !rs) begin
        dut_handoff_cyc.push_back(cyc);
        dut_words.push_back(bus.out_word);
      end
    end
    @(posedge clk);
    if (rs) begin
      pend.delete();
      m_full  = 1'b0;
      m_known = 1'b1;
    end else if (clr) begin
      pend.delete();
      m_full = 1'b0;
    end else begin
      acc = iv && exp_rdy;
      if (m_full && ordy) begin
        m_full = 1'b0;
        m_handoffs++;
      end
      if (acc) begin
        pend.push_back(ib);
        if (pend.size() == 16) begin
          m_word = '0;
          for (int k = 0; k < 16; k++) m_word[8*k +: 8] = pend[k];
          m_full = 1'b1;
          pend.delete();
        end
      end
    end
    cyc++;
    #1;
  endtask

  initial begin
    int base;
    int h0;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    m_full      = 1'b0;
    m_word      = '0;
    m_known     = 1'b0;
    m_handoffs  = 0;
    rst         = 1'b1;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_byte = '0; bus.out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_out_word", bus.out_word, 128'h0);
    chk("rst_in_ready", 128'(bus.in_ready), 128'h1);
    chk("rst_level", 128'(bus.level), 128'h0);

    // 16 consecutive bytes 0x00..0x0F
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    #4;
    chk("seq_out_valid", 128'(bus.out_valid), 128'h1);
    chk("seq_word", bus.out_word, 128'h0F0E0D0C0B0A09080706050403020100);
    #0;

    // Consumer stall for 5 cycles, then hand-off with simultaneous accept
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
      chk("stall_word", bus.out_word, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("stall_level", 128'(bus.level), 128'h0);
    end
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    chk("resume_level", 128'(bus.level), 128'h1);
    chk("resume_lane0", 128'(bus.out_word[7:0]), 128'h77);

    // Back-to-back 48 bytes
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    dut_handoff_cyc.delete();
    dut_words.delete();
    base = cyc;
    h0 = m_handoffs;
    for (int i = 0; i < 48; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("b2b_count", 128'(dut_handoff_cyc.size()), 128'd3);
    chk("b2b_model_count", 128'(m_handoffs - h0), 128'd3);
    if (dut_handoff_cyc.size() == 3) begin
      chk("b2b_t1", 128'(dut_handoff_cyc[0] - base), 128'd16);
      chk("b2b_t2", 128'(dut_handoff_cyc[1] - base), 128'd32);
      chk("b2b_t3", 128'(dut_handoff_cyc[2] - base), 128'd48);
      chk("b2b_w2_lane0", 128'(dut_words[1][7:0]), 128'h10);
      chk("b2b_w3", dut_words[2], 128'h2F2E2D2C2B2A29282726252423222120);
    end

    // Gapped input, in_valid toggling
    for (int i = 0; i < 32; i++) step((i % 2) == 0, 8'hA0 + 8'(i / 2), 1'b0, 1'b0, 1'b0);
    #4;
    chk("gap_valid", 128'(bus.out_valid), 128'h1);
    chk("gap_word", bus.out_word, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    #0;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // clear at level 7, then a full word
    for (int i = 0; i < 7; i++) step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("pre_clear_level", 128'(bus.level), 128'h7);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    chk("post_clear_level", 128'(bus.level), 128'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
    #4;
    chk("clr_word", bus.out_word, 128'h5F5E5D5C5B5A59585756555453525150);
    #0;
    h0 = dut_handoff_cyc.size();
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("clr_full_valid", 128'(bus.out_valid), 128'h0);
    chk("clr_full_nohandoff", 128'(dut_handoff_cyc.size()), 128'(h0));

    // Random stretch
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 50) == 0, 1'b0);
    end

    // Reset mid-fill at level 9 together with clear and in_valid
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", 128'(bus.level), 128'h9);
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
    rst = 1'b0; bus.clear = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("rst2_level", 128'(bus.level), 128'h0);
    chk("rst2_out_valid", 128'(bus.out_valid), 128'h0);
    chk("rst2_out_word", bus.out_word, 128'h0);
    chk("rst2_in_ready", 128'(bus.in_ready), 128'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
